// File: rtl/button_reader.sv
// Debounced button reader: two-flop synchronizer, counter-qualified press/release FSM,
// registered level, press/release/long-press strobes and a wrapping 4-bit press counter.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       CLK_IN,
  input  logic       RESET_N,
  input  logic       BTN_IN,
  output logic       BTN_LEVEL,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic       LONG_PULSE,
  output logic [3:0] PRESS_COUNT
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic          REL_LVL   = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_QUAL   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_QUAL = 2'd3
  } state_t;

  logic          sync1_q, sync2_q;
  logic          pressed_s;
  state_t        state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_flag_q, long_flag_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic [3:0]    count_q, count_d;
  logic          holding_s;

  // Two-flop synchronizer, parked at the released pin level during reset.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= BTN_IN;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign holding_s = (state_q == S_PRESSED) || (state_q == S_RELEASE_QUAL);

  // Next-state and output decode for the qualification FSM.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_d      = hold_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    count_d     = count_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    // Hold timing runs through RELEASE_QUAL so a bounce mid-hold does not restart it.
    if (holding_s && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      S_RELEASED: begin
        if (pressed_s) begin
          state_d  = S_PRESS_QUAL;
          db_cnt_d = DB_ONE;
        end else begin
          db_cnt_d = '0;
        end
      end
      S_PRESS_QUAL: begin
        if (!pressed_s) begin
          state_d  = S_RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = S_PRESSED;
          db_cnt_d    = '0;
          press_d     = 1'b1;
          level_d     = 1'b1;
          count_d     = count_q + 4'd1;
          hold_d      = '0;
          long_flag_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      S_PRESSED: begin
        if (!pressed_s) begin
          state_d  = S_RELEASE_QUAL;
          db_cnt_d = DB_ONE;
        end else begin
          db_cnt_d = '0;
        end
      end
      S_RELEASE_QUAL: begin
        if (pressed_s) begin
          state_d  = S_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = S_RELEASED;
          db_cnt_d  = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = S_RELEASED;
        db_cnt_d = '0;
        level_d  = 1'b0;
      end
    endcase

    // A release qualifying on the long-threshold cycle wins over the long strobe.
    if (holding_s && (hold_q == HOLD_LAST) && !long_flag_q && !release_d) begin
      long_d      = 1'b1;
      long_flag_d = 1'b1;
    end else begin
      long_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_RELEASED;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  assign BTN_LEVEL     = level_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign LONG_PULSE    = long_q;
  assign PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios plus random pin activity, every cycle
// compared against a run-length reference model of debounce and long-press timing.
module tb_button_reader;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam bit AL = 1'b1;

  logic       CLK_IN = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BTN_IN = 1'b1;
  logic       BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE;
  logic [3:0] PRESS_COUNT;

  always #5 CLK_IN = ~CLK_IN;

  button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(AL)) dut (
    .CLK_IN(CLK_IN), .RESET_N(RESET_N), .BTN_IN(BTN_IN),
    .BTN_LEVEL(BTN_LEVEL), .PRESS_PULSE(PRESS_PULSE), .RELEASE_PULSE(RELEASE_PULSE),
    .LONG_PULSE(LONG_PULSE), .PRESS_COUNT(PRESS_COUNT)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_n = 0, release_n = 0, long_n = 0;
  int last_press_cyc = 0, last_long_cyc = 0;

  // Reference model: the qualifier sees the pin two edges late; the level flips after
  // D consecutive samples that disagree with it; long fires L edges after a press.
  bit m_h1, m_h2, m_lvl;
  int m_streak, m_since, m_cnt;
  bit e_press, e_rel, e_long;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_h1 = 1'b0; m_h2 = 1'b0; m_lvl = 1'b0;
    m_streak = 0; m_since = 0; m_cnt = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    bit pv;
    pv = m_h2;
    m_h2 = m_h1;
    m_h1 = AL ? !b : b;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (pv != m_lvl) begin
      m_streak++;
      if (m_streak == D) begin
        m_lvl = pv;
        m_streak = 0;
        if (m_lvl) begin
          e_press = 1'b1;
          m_cnt = (m_cnt + 1) % 16;
          m_since = 0;
        end else begin
          e_rel = 1'b1;
        end
      end
    end else begin
      m_streak = 0;
    end
    if (m_lvl && !e_press) begin
      m_since++;
      if (m_since == L) e_long = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"},   32'(BTN_LEVEL),     32'(0));
    check({tag, "_press"},   32'(PRESS_PULSE),   32'(0));
    check({tag, "_release"}, 32'(RELEASE_PULSE), 32'(0));
    check({tag, "_long"},    32'(LONG_PULSE),    32'(0));
    check({tag, "_count"},   32'(PRESS_COUNT),   32'(0));
  endtask

  // One clock: drive at the falling edge, model the rising edge, sample at the next fall.
  task automatic cycle(input logic b);
    BTN_IN = b;
    @(posedge CLK_IN);
    model_edge(b);
    cyc++;
    @(negedge CLK_IN);
    if (PRESS_PULSE)   begin press_n++;   last_press_cyc = cyc; end
    if (RELEASE_PULSE) release_n++;
    if (LONG_PULSE)    begin long_n++;    last_long_cyc = cyc; end
    check("m_level",   32'(BTN_LEVEL),     32'(m_lvl));
    check("m_press",   32'(PRESS_PULSE),   32'(e_press));
    check("m_release", 32'(RELEASE_PULSE), 32'(e_rel));
    check("m_long",    32'(LONG_PULSE),    32'(e_long));
    check("m_count",   32'(PRESS_COUNT),   32'(m_cnt));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 RESET_N = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    RESET_N = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, l0, r0, pc, lvl, len;
    model_reset();
    RESET_N = 1'b0;
    BTN_IN = 1'b1;
    repeat (3) @(negedge CLK_IN);
    check_zero("reset");
    RESET_N = 1'b1;
    repeat (50) cycle(1'b1);
    check("idle_press_n", 32'(press_n), 32'(0));
    check("idle_release_n", 32'(release_n), 32'(0));

    // Clean press and release latency.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      if (i == 4) check("press_early", 32'(PRESS_PULSE), 32'(0));
    end
    check("press_edge5", 32'(PRESS_PULSE), 32'(1));
    check("press_level", 32'(BTN_LEVEL), 32'(1));
    check("press_count", 32'(PRESS_COUNT), 32'(1));
    cycle(1'b0);
    check("press_width", 32'(PRESS_PULSE), 32'(0));
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1);
      if (i == 4) check("release_early", 32'(RELEASE_PULSE), 32'(0));
    end
    check("release_edge5", 32'(RELEASE_PULSE), 32'(1));
    check("release_level", 32'(BTN_LEVEL), 32'(0));
    repeat (4) cycle(1'b1);

    // Bouncing contact never stays low for D samples.
    p0 = press_n;
    repeat (4) begin
      repeat (3) cycle(1'b0);
      cycle(1'b1);
    end
    check("bounce_no_press", 32'(press_n - p0), 32'(0));
    check("bounce_level", 32'(BTN_LEVEL), 32'(0));
    repeat (8) cycle(1'b0);
    check("bounce_then_press", 32'(press_n - p0), 32'(1));
    repeat (8) cycle(1'b1);

    // Long press with a one-cycle glitch ten cycles into the hold.
    p0 = press_n;
    l0 = long_n;
    repeat (6) cycle(1'b0);
    check("long_press_seen", 32'(press_n - p0), 32'(1));
    pc = last_press_cyc;
    for (int i = 1; i < 40; i++) cycle((i == 10) ? 1'b1 : 1'b0);
    check("long_once", 32'(long_n - l0), 32'(1));
    check("long_delay", 32'(last_long_cyc - pc), 32'(L));
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("long_release", 32'(RELEASE_PULSE), 32'(1));
    repeat (4) cycle(1'b1);

    // Counter wrap over 17 presses from a fresh reset.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      repeat (6) cycle(1'b0);
      check("wrap_count", 32'(PRESS_COUNT), 32'((k + 1) % 16));
      repeat (6) cycle(1'b1);
    end

    // Reset while held: no release strobe, press requalifies at normal latency.
    repeat (8) cycle(1'b0);
    check("held_level", 32'(BTN_LEVEL), 32'(1));
    r0 = release_n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      if (i == 4) check("rst_press_early", 32'(PRESS_PULSE), 32'(0));
    end
    check("rst_press_edge5", 32'(PRESS_PULSE), 32'(1));
    check("rst_press_count", 32'(PRESS_COUNT), 32'(1));
    check("rst_no_release", 32'(release_n - r0), 32'(0));
    repeat (6) cycle(1'b1);

    // Random pin activity with runs long enough to reach long presses sometimes.
    repeat (150) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 35));
      repeat (len) cycle(lvl[0]);
    end
    repeat (40) cycle(1'b1);
    check("final_released", 32'(BTN_LEVEL), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
